// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: in-order circular queue of
// {pc, instr, misaligned} entries with valid/ready on both sides and a flush.
module fetch_queue #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [WORD_SIZE-1:0] push_pc,
    input  logic [WORD_SIZE-1:0] push_instr,
    output logic                 pop_valid,
    input  logic                 pop_ready,
    output logic [WORD_SIZE-1:0] pop_pc,
    output logic [WORD_SIZE-1:0] pop_instr,
    output logic [WORD_SIZE-1:0] pop_pc_next,
    output logic                 pop_misaligned,
    output logic [PTR_WIDTH:0]   count
);

    localparam int unsigned CNT_W = PTR_WIDTH + 1;

    logic [WORD_SIZE-1:0] r_pc_mem    [0:DEPTH-1];
    logic [WORD_SIZE-1:0] r_instr_mem [0:DEPTH-1];
    logic                 r_mis_mem   [0:DEPTH-1];

    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic w_push;
    logic w_pop;

    // push_ready depends only on occupancy, so pop_ready never reaches it
    assign push_ready = (r_count != CNT_W'(DEPTH));
    assign pop_valid  = (r_count != '0);
    assign w_push     = push_valid & push_ready & ~flush & ~reset;
    assign w_pop      = pop_valid & pop_ready & ~flush & ~reset;

    assign pop_pc         = r_pc_mem[r_rd_ptr];
    assign pop_instr      = r_instr_mem[r_rd_ptr];
    assign pop_misaligned = r_mis_mem[r_rd_ptr];
    assign pop_pc_next    = pop_pc + WORD_SIZE'(2);
    assign count          = r_count;

    // Entry storage; contents are never cleared, occupancy alone marks validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= push_pc;
            r_instr_mem[r_wr_ptr] <= push_instr;
            r_mis_mem[r_wr_ptr]   <= push_pc[0];
        end
    end

    // Pointers and occupancy; flush realigns the read pointer onto the write pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven fill/drain vectors plus
// hand-written sequences, with a queue scoreboard checking every popped entry.
module tb_fetch_queue;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned PTR_WIDTH = 2;

    logic                 clk;
    logic                 reset;
    logic                 flush;
    logic                 push_valid;
    logic                 push_ready;
    logic [WORD_SIZE-1:0] push_pc;
    logic [WORD_SIZE-1:0] push_instr;
    logic                 pop_valid;
    logic                 pop_ready;
    logic [WORD_SIZE-1:0] pop_pc;
    logic [WORD_SIZE-1:0] pop_instr;
    logic [WORD_SIZE-1:0] pop_pc_next;
    logic                 pop_misaligned;
    logic [PTR_WIDTH:0]   count;

    fetch_queue #(
        .WORD_SIZE(WORD_SIZE),
        .DEPTH    (DEPTH),
        .PTR_WIDTH(PTR_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .push_pc       (push_pc),
        .push_instr    (push_instr),
        .pop_valid     (pop_valid),
        .pop_ready     (pop_ready),
        .pop_pc        (pop_pc),
        .pop_instr     (pop_instr),
        .pop_pc_next   (pop_pc_next),
        .pop_misaligned(pop_misaligned),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        mis;
    } entry_t;

    typedef struct {
        logic        rs;
        logic        fl;
        logic        pv;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        pr;
        int          exp_count_after;
    } vec_t;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check against the model, then take the edge
    task automatic step(input logic pv, input logic [15:0] pc, input logic [15:0] instr,
                        input logic pr, input logic fl, input logic rs);
        entry_t e;
        logic   acc_push;
        @(negedge clk);
        push_valid = pv;
        push_pc    = pc;
        push_instr = instr;
        pop_ready  = pr;
        flush      = fl;
        reset      = rs;
        #1;
        chk("pop_valid", 32'(pop_valid), 32'(sb.size() != 0));
        chk("push_ready", 32'(push_ready), 32'(sb.size() != DEPTH));
        chk("count", 32'(count), 32'(sb.size()));
        acc_push = pv && (sb.size() != DEPTH) && !fl && !rs;
        if (rs || fl) begin
            sb.delete();
        end else begin
            if (pr && sb.size() != 0) begin
                e = sb.pop_front();
                chk("pop_pc", 32'(pop_pc), 32'(e.pc));
                chk("pop_instr", 32'(pop_instr), 32'(e.instr));
                chk("pop_misaligned", 32'(pop_misaligned), 32'(e.mis));
                chk("pop_pc_next", 32'(pop_pc_next), 32'(16'(e.pc + 16'd2)));
            end
            if (acc_push) begin
                e.pc    = pc;
                e.instr = instr;
                e.mis   = pc[0];
                sb.push_back(e);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic pr);
        step(1'b0, 16'h0, 16'h0, pr, 1'b0, 1'b0);
    endtask

    vec_t vecs[11];

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        push_valid = 1'b0;
        push_pc    = '0;
        push_instr = '0;
        pop_ready  = 1'b0;
        repeat (2) @(posedge clk);

        // Fill to full with pop stalled, reject a 5th push, then drain in order
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'hA000, 1'b0, 1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 16'hA001, 1'b0, 2};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0004, 16'hA002, 1'b0, 3};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0006, 16'hA003, 1'b0, 4};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0008, 16'hA004, 1'b0, 4};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 3};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0};
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].pv, vecs[i].pc, vecs[i].instr, vecs[i].pr, vecs[i].fl, vecs[i].rs);
            #1;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count_after));
            chk($sformatf("vec%0d_pop_valid", i), 32'(pop_valid),
                32'(vecs[i].exp_count_after != 0));
        end

        // Full queue with simultaneous push and pop: pop happens, push is refused
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0400 + 16'(2 * i), 16'hC000 + 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0408, 16'hC004, 1'b1, 1'b0, 1'b0);
        #1;
        chk("full_pushpop_count", 32'(count), 32'd3);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Continuous streaming from empty, 12 entries: pointers wrap three times
        for (int i = 0; i < 12; i++) step(1'b1, 16'h0200 + 16'(2 * i), 16'hB000 + 16'(i), 1'b1, 1'b0, 1'b0);
        #1;
        chk("stream_count", 32'(count), 32'd1);
        idle(1'b1);
        idle(1'b0);

        // Flush with 3 entries plus a same-cycle push and pop
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0300 + 16'(2 * i), 16'hD000 + 16'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0306, 16'hD003, 1'b1, 1'b1, 1'b0);
        #1;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_pop_valid", 32'(pop_valid), 32'd0);
        idle(1'b1);
        step(1'b1, 16'h0100, 16'hE100, 1'b0, 1'b0, 1'b0);
        #1;
        chk("after_flush_head_pc", 32'(pop_pc), 32'h0100);
        idle(1'b1);

        // Misaligned tag and pc_next wrap
        step(1'b1, 16'h0003, 16'hF003, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        #1;
        chk("mis_head_flag", 32'(pop_misaligned), 32'd1);
        idle(1'b1);
        #1;
        chk("wrap_head_flag", 32'(pop_misaligned), 32'd0);
        chk("wrap_pc_next", 32'(pop_pc_next), 32'h0000);
        idle(1'b1);

        // Reset mid-stream overrides push and flush
        step(1'b1, 16'h0500, 16'h5500, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0502, 16'h5502, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0504, 16'h5504, 1'b1, 1'b1, 1'b1);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        step(1'b1, 16'h0600, 16'h6600, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0602, 16'h6602, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
